muldiv_sequencer: RTL and testbench

//  Sequencer for the shared mult/div units and the HI/LO registers. Sits between Control_Unit and
//  the mult, div, mux_divSrcA and mux_hi_lo instances: issues the init pulse, waits a fixed latency,

---
 rtl/muldiv_sequencer_pkg.sv | 25 ++
 rtl/muldiv_sequencer_if.sv | 25 ++
 rtl/muldiv_latency_counter.sv | 27 ++
 rtl/muldiv_sequencer.sv | 82 ++++++++
 tb/tb_muldiv_sequencer.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_sequencer_pkg.sv
// Shared encodings for the mult/div sequencer: op codes, FSM states and HI/LO source select.
// Control_Unit imports the same package so both sides agree on the op encoding.
package muldiv_sequencer_pkg;

  typedef logic [1:0] op_t;

  localparam op_t OP_MULT = 2'b00;
  localparam op_t OP_DIV  = 2'b01;
  localparam op_t OP_DIVM = 2'b10;
  localparam op_t OP_ILL  = 2'b11;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_INIT  = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_EXC   = 3'd4;

  localparam logic HL_SEL_DIV  = 1'b0;
  localparam logic HL_SEL_MULT = 1'b1;

  function automatic logic is_div_op(input op_t op);
    return (op == OP_DIV) || (op == OP_DIVM);
  endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Handshake between Control_Unit (master) and the mult/div sequencer (slave),
// including the control lines the sequencer fans out to mult, div and the HI/LO muxes.
interface muldiv_sequencer_if;
  logic       start;
  logic [1:0] op;
  logic       b_is_zero;
  logic       busy;
  logic       done;
  logic       div_zero_exc;
  logic       mult_init;
  logic       div_init;
  logic       div_op;
  logic       hl_sel;
  logic       hl_load;

  modport master (
    output start, op, b_is_zero,
    input  busy, done, div_zero_exc, mult_init, div_init, div_op, hl_sel, hl_load
  );

  modport slave (
    input  start, op, b_is_zero,
    output busy, done, div_zero_exc, mult_init, div_init, div_op, hl_sel, hl_load
  );
endinterface

// File: rtl/muldiv_latency_counter.sv
// Down-counter that times the fixed mult/div latency; saturates at zero so it never wraps.
module muldiv_latency_counter #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/muldiv_sequencer.sv
// Sequences one mult or div operation: init pulse, fixed-latency wait, then HI/LO commit.
// Every output decodes from state/op_q only, so start never reaches an output combinationally.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int MULT_CYCLES = 32,
  parameter int DIV_CYCLES  = 32,
  parameter int CNT_W       = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  muldiv_sequencer_if.slave    bus
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  logic [2:0] state, state_n;
  op_t        op_q, op_n;
  logic       cnt_load, cnt_dec, cnt_zero;
  logic       in_op;

  always_comb begin
    state_n = state;
    op_n    = op_q;
    case (state)
      ST_IDLE: begin
        if (bus.start && (bus.op != OP_ILL)) begin
          if (is_div_op(bus.op) && bus.b_is_zero) begin
            state_n = ST_EXC;
          end else begin
            state_n = ST_INIT;
            op_n    = bus.op;
          end
        end
      end
      ST_INIT:  state_n = ST_WAIT;
      ST_WAIT:  if (cnt_zero) state_n = ST_WRITE;
      ST_WRITE: state_n = ST_IDLE;
      ST_EXC:   state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      op_q  <= OP_MULT;
    end else begin
      state <= state_n;
      op_q  <= op_n;
    end
  end

  // Counter holds N-1 on entry to WAIT, so WAIT lasts exactly N cycles.
  assign cnt_load = (state == ST_INIT);
  assign cnt_dec  = (state == ST_WAIT);

  muldiv_latency_counter #(
    .CNT_W (CNT_W)
  ) u_latency_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val ((op_q == OP_MULT) ? MULT_LOAD : DIV_LOAD),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  assign in_op = (state == ST_INIT) || (state == ST_WAIT) || (state == ST_WRITE);

  assign bus.busy         = (state != ST_IDLE);
  assign bus.done         = (state == ST_WRITE);
  assign bus.hl_load      = (state == ST_WRITE);
  assign bus.div_zero_exc = (state == ST_EXC);
  assign bus.mult_init    = (state == ST_INIT) && (op_q == OP_MULT);
  assign bus.div_init     = (state == ST_INIT) && (op_q != OP_MULT);
  // div operand select held through WRITE so the divider sees stable inputs.
  assign bus.div_op       = in_op && (op_q == OP_DIVM);
  assign bus.hl_sel       = (in_op && (op_q == OP_MULT)) ? HL_SEL_MULT : HL_SEL_DIV;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: two instances (32/32 and 1/5 latency) checked cycle by cycle
// against a timeline model of what every output should be k cycles after start is accepted.
module tb_muldiv_sequencer;
  import muldiv_sequencer_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       sel;
  logic [1:0] op;
  logic       b_is_zero;
  logic [7:0] obs_a, obs_b, obs;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  muldiv_sequencer_if bus_a();
  muldiv_sequencer_if bus_b();

  assign bus_a.start     = start & ~sel;
  assign bus_a.op        = op;
  assign bus_a.b_is_zero = b_is_zero;
  assign bus_b.start     = start & sel;
  assign bus_b.op        = op;
  assign bus_b.b_is_zero = b_is_zero;

  muldiv_sequencer #(.MULT_CYCLES(32), .DIV_CYCLES(32), .CNT_W(6)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a.slave)
  );

  muldiv_sequencer #(.MULT_CYCLES(1), .DIV_CYCLES(5), .CNT_W(3)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b.slave)
  );

  // {busy, done, div_zero_exc, mult_init, div_init, div_op, hl_sel, hl_load}
  assign obs_a = {bus_a.busy, bus_a.done, bus_a.div_zero_exc, bus_a.mult_init,
                  bus_a.div_init, bus_a.div_op, bus_a.hl_sel, bus_a.hl_load};
  assign obs_b = {bus_b.busy, bus_b.done, bus_b.div_zero_exc, bus_b.mult_init,
                  bus_b.div_init, bus_b.div_op, bus_b.hl_sel, bus_b.hl_load};
  assign obs   = sel ? obs_b : obs_a;

  function automatic int cycles_of(input logic s, input logic [1:0] o);
    if (!s) return 32;
    return (o == 2'b00) ? 1 : 5;
  endfunction

  // Expected outputs in cycle k after the accepting edge (k=1 is the first cycle after it).
  function automatic logic [7:0] expect_vec(input int k, input logic [1:0] o, input logic bz,
                                            input int n);
    logic bsy, dn, exc, mi, di, dop, hs, hl;
    {bsy, dn, exc, mi, di, dop, hs, hl} = 8'h00;
    if (o == 2'b11) begin
      bsy = 1'b0;
    end else if ((o != 2'b00) && bz) begin
      bsy = (k == 1);
      exc = (k == 1);
    end else if (k >= 1 && k <= n + 2) begin
      bsy = 1'b1;
      mi  = (k == 1) && (o == 2'b00);
      di  = (k == 1) && (o != 2'b00);
      dop = (o == 2'b10);
      hs  = (o == 2'b00);
      dn  = (k == n + 2);
      hl  = (k == n + 2);
    end
    return {bsy, dn, exc, mi, di, dop, hs, hl};
  endfunction

  // Call just after a falling edge; returns just after the falling edge of the first idle cycle.
  task automatic issue(input string name, input logic [1:0] o, input logic bz, input bit garbage);
    int         n, last;
    bit         noisy;
    logic [7:0] exp;
    n     = cycles_of(sel, o);
    noisy = garbage && (o != 2'b11);
    if (o == 2'b11)                 last = 3;
    else if ((o != 2'b00) && bz)    last = 2;
    else                            last = n + 3;
    start     = 1'b1;
    op        = o;
    b_is_zero = bz;
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      exp = expect_vec(k, o, bz, n);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL %s op=%0d bz=%0b k=%0d got=%b expected=%b", name, o, bz, k, obs, exp);
      end
      start     = (noisy && k < last) ? 1'($urandom_range(0, 1)) : 1'b0;
      op        = 2'($urandom_range(0, 3));
      b_is_zero = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic idle_cycles(input string name, input int m);
    for (int i = 0; i < m; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== 8'h00) begin
        errors++;
        $display("FAIL %s idle cycle %0d got=%b expected=00000000", name, i, obs);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; sel = 1'b0; op = 2'b00; b_is_zero = 1'b0;
    #1;
    checks++;
    if (obs_a !== 8'h00) begin errors++; $display("FAIL reset_a got=%b expected=00000000", obs_a); end
    checks++;
    if (obs_b !== 8'h00) begin errors++; $display("FAIL reset_b got=%b expected=00000000", obs_b); end
    start = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (obs_a !== 8'h00) begin errors++; $display("FAIL reset_hold got=%b expected=00000000", obs_a); end
    start = 1'b0;
    #2 reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mult();
    sel = 1'b0;
    issue("mult", 2'b00, 1'b0, 1'b0);
  endtask

  task automatic test_divm();
    sel = 1'b0;
    issue("divm", 2'b10, 1'b0, 1'b0);
    issue("div", 2'b01, 1'b0, 1'b0);
  endtask

  task automatic test_div_zero();
    sel = 1'b0;
    issue("div_zero", 2'b01, 1'b1, 1'b0);
    issue("divm_zero", 2'b10, 1'b1, 1'b0);
    issue("mult_bz_ignored", 2'b00, 1'b1, 1'b0);
  endtask

  task automatic test_illegal_busy();
    sel = 1'b0;
    issue("illegal", 2'b11, 1'b0, 1'b0);
    issue("busy_ignore", 2'b00, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    sel = 1'b0;
    issue("b2b_first", 2'b10, 1'b0, 1'b1);
    issue("b2b_second", 2'b00, 1'b0, 1'b1);
    issue("b2b_exc", 2'b01, 1'b1, 1'b1);
    issue("b2b_after_exc", 2'b01, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_op();
    sel = 1'b0;
    start = 1'b1; op = 2'b00; b_is_zero = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    checks++;
    if (obs_a !== 8'b1000_0010) begin
      errors++;
      $display("FAIL mid_op_before_reset got=%b expected=10000010", obs_a);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (obs_a !== 8'h00) begin
      errors++;
      $display("FAIL mid_op_async_reset got=%b expected=00000000", obs_a);
    end
    @(negedge clk);
    #3 reset = 1'b1;
    idle_cycles("after_reset_no_done", 40);
    issue("post_reset_mult", 2'b00, 1'b0, 1'b0);
  endtask

  task automatic test_param_sweep();
    sel = 1'b1;
    issue("sweep_mult1", 2'b00, 1'b0, 1'b0);
    issue("sweep_div5", 2'b01, 1'b0, 1'b0);
    issue("sweep_divm5", 2'b10, 1'b0, 1'b1);
    issue("sweep_mult1_b2b", 2'b00, 1'b0, 1'b1);
    issue("sweep_zero", 2'b10, 1'b1, 1'b0);
    idle_cycles("sweep_idle", 4);
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      sel = 1'($urandom_range(0, 1));
      issue("random", 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b1);
      if ($urandom_range(0, 1) == 1) idle_cycles("random_gap", $urandom_range(1, 3));
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_divm();
    test_div_zero();
    test_illegal_busy();
    test_back_to_back();
    test_reset_mid_op();
    test_param_sweep();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
